// File: rtl/rbm_gibbs_scheduler.sv
// rbm_gibbs_scheduler
//   Drives one hidden-layer and one visible-layer RBMLayer datapath through
//   gibbs_steps Gibbs step pairs (v->h->v...). Each phase pulses the layer
//   reset for one cycle, then holds the layer's data_valid until it reports
//   finish, at which point the sampled vector is captured. Hidden samples feed
//   the visible layer and vice versa. Final samples are presented with a
//   one-cycle done pulse.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   start                 run request, honoured only in IDLE
//   vis_in                initial visible vector, captured on accepted start
//   busy / done           run in progress / one-cycle results-valid pulse
//   vis_out / hid_out     last visible / hidden sample, held until next done
//   h_reset/h_valid/h_finish/h_in/h_data   hidden-layer handshake and data
//   v_reset/v_valid/v_finish/v_in/v_data   visible-layer handshake and data
//   rand_reset            shared random generator reseed strobe (first run after reset)
//   error                 watchdog abort flag
//
// Optional feature: define RBM_SCHED_TIMEOUT_EN to enable a per-phase
// watchdog of timeout_cycles; without it error is tied low and RUN phases
// wait indefinitely.
module rbm_gibbs_scheduler #(
  parameter int bitlength      = 12,
  parameter int visible_dim    = 15,
  parameter int hidden_dim     = 5,
  parameter int gibbs_steps    = 1,
  parameter int timeout_cycles = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [visible_dim*bitlength-1:0] vis_in,
  output logic                             busy,
  output logic                             done,
  output logic [visible_dim*bitlength-1:0] vis_out,
  output logic [hidden_dim*bitlength-1:0]  hid_out,
  output logic                             h_reset,
  output logic                             h_valid,
  input  logic                             h_finish,
  output logic [visible_dim*bitlength-1:0] h_in,
  input  logic [hidden_dim*bitlength-1:0]  h_data,
  output logic                             v_reset,
  output logic                             v_valid,
  input  logic                             v_finish,
  output logic [hidden_dim*bitlength-1:0]  v_in,
  input  logic [visible_dim*bitlength-1:0] v_data,
  output logic                             rand_reset,
  output logic                             error
);

  localparam int VW = visible_dim * bitlength;
  localparam int HW = hidden_dim * bitlength;
  localparam int SW = (gibbs_steps > 0) ? $clog2(gibbs_steps + 1) : 1;
  localparam logic [SW-1:0] STEP_LAST = gibbs_steps[SW-1:0];

  // A zero watchdog limit would abort every phase on its first RUN cycle.
  if (timeout_cycles < 1) begin : g_bad_timeout
    $error("rbm_gibbs_scheduler: timeout_cycles must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_H_RST = 3'd1,
    S_H_RUN = 3'd2,
    S_V_RST = 3'd3,
    S_V_RUN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_r, state_nx_s;
  logic [SW-1:0]   step_r;
  logic            seeded_r;
  logic [VW-1:0]   vis_reg_r, vis_out_r;
  logic [HW-1:0]   hid_reg_r, hid_out_r;
  logic            busy_r, done_r, h_reset_r, v_reset_r, h_valid_r, v_valid_r, rand_reset_r;
  logic            accept_s, h_cap_s, v_cap_s;

`ifdef RBM_SCHED_TIMEOUT_EN
  localparam int TW       = $clog2(timeout_cycles + 1);
  localparam int TMO_LAST = timeout_cycles - 1;
  logic [TW-1:0]   tmo_r;
  logic            tmo_hit_s, abort_s, error_r;
  assign tmo_hit_s = (tmo_r == TMO_LAST[TW-1:0]);
`endif

  // Next-state decode; finish inputs only matter in their own RUN state.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    h_cap_s    = 1'b0;
    v_cap_s    = 1'b0;
`ifdef RBM_SCHED_TIMEOUT_EN
    abort_s    = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = S_H_RST;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_H_RST: state_nx_s = S_H_RUN;
      S_H_RUN: begin
        if (h_finish) begin
          h_cap_s    = 1'b1;
          state_nx_s = (step_r == STEP_LAST) ? S_DONE : S_V_RST;
        end
`ifdef RBM_SCHED_TIMEOUT_EN
        else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = S_IDLE;
        end
`endif
        else begin
          state_nx_s = S_H_RUN;
        end
      end
      S_V_RST: state_nx_s = S_V_RUN;
      S_V_RUN: begin
        if (v_finish) begin
          v_cap_s    = 1'b1;
          state_nx_s = S_H_RST;
        end
`ifdef RBM_SCHED_TIMEOUT_EN
        else if (tmo_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = S_IDLE;
        end
`endif
        else begin
          state_nx_s = S_V_RUN;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register and control strobes, registered from the next state so
  // each strobe is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      h_reset_r    <= 1'b1;
      v_reset_r    <= 1'b1;
      h_valid_r    <= 1'b0;
      v_valid_r    <= 1'b0;
      rand_reset_r <= 1'b1;
      seeded_r     <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      busy_r       <= (state_nx_s != S_IDLE);
      done_r       <= (state_nx_s == S_DONE);
      h_reset_r    <= (state_nx_s == S_H_RST);
      v_reset_r    <= (state_nx_s == S_V_RST);
      h_valid_r    <= (state_nx_s == S_H_RUN);
      v_valid_r    <= (state_nx_s == S_V_RUN);
      // The generator is reseeded once, on the first hidden phase after reset.
      rand_reset_r <= (state_nx_s == S_H_RST) && !seeded_r;
      if (state_nx_s == S_H_RST) begin
        seeded_r <= 1'b1;
      end
    end
  end

  // Sample registers, step counter and result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vis_reg_r <= {VW{1'b0}};
      hid_reg_r <= {HW{1'b0}};
      vis_out_r <= {VW{1'b0}};
      hid_out_r <= {HW{1'b0}};
      step_r    <= {SW{1'b0}};
    end else begin
      if (accept_s) begin
        vis_reg_r <= vis_in;
        step_r    <= {SW{1'b0}};
      end else if (v_cap_s) begin
        vis_reg_r <= v_data;
        step_r    <= step_r + SW'(1);
      end
      if (h_cap_s) begin
        hid_reg_r <= h_data;
      end
      // Results are published on the final capture edge so they are valid
      // in the same cycle as done.
      if (h_cap_s && (state_nx_s == S_DONE)) begin
        vis_out_r <= vis_reg_r;
        hid_out_r <= h_data;
      end
    end
  end

`ifdef RBM_SCHED_TIMEOUT_EN
  // Watchdog: counts RUN cycles; RST always precedes RUN so it starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_r   <= {TW{1'b0}};
      error_r <= 1'b0;
    end else begin
      if ((state_r == S_H_RUN) || (state_r == S_V_RUN)) begin
        tmo_r <= tmo_r + TW'(1);
      end else begin
        tmo_r <= {TW{1'b0}};
      end
      if (accept_s) begin
        error_r <= 1'b0;
      end else if (abort_s) begin
        error_r <= 1'b1;
      end
    end
  end
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign vis_out    = vis_out_r;
  assign hid_out    = hid_out_r;
  assign h_reset    = h_reset_r;
  assign h_valid    = h_valid_r;
  assign h_in       = vis_reg_r;
  assign v_reset    = v_reset_r;
  assign v_valid    = v_valid_r;
  assign v_in       = hid_reg_r;
  assign rand_reset = rand_reset_r;

endmodule

// File: tb/tb_rbm_gibbs_scheduler.sv
// Testbench for rbm_gibbs_scheduler: two instances (gibbs_steps=1 and 0)
// share stub layer models; a behavioural model predicts phase order,
// latency, routed vectors and final results for each run.
`timescale 1ns/1ps
module tb_rbm_gibbs_scheduler;
  localparam int BL = 12, VD = 15, HD = 5, VW = VD * BL, HW = HD * BL, TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic start_a = 1'b0, start_b = 1'b0;
  logic [VW-1:0] vis_in = '0;
  logic h_finish = 1'b0, v_finish = 1'b0;
  logic [HW-1:0] h_data = '0;
  logic [VW-1:0] v_data = '0;

  logic a_busy, a_done, a_h_reset, a_h_valid, a_v_reset, a_v_valid, a_rand_reset, a_error;
  logic b_busy, b_done, b_h_reset, b_h_valid, b_v_reset, b_v_valid, b_rand_reset, b_error;
  logic [VW-1:0] a_vis_out, a_h_in, b_vis_out, b_h_in;
  logic [HW-1:0] a_hid_out, a_v_in, b_hid_out, b_v_in;

  rbm_gibbs_scheduler #(.bitlength(BL), .visible_dim(VD), .hidden_dim(HD),
                        .gibbs_steps(1), .timeout_cycles(TMO)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .vis_in(vis_in),
    .busy(a_busy), .done(a_done), .vis_out(a_vis_out), .hid_out(a_hid_out),
    .h_reset(a_h_reset), .h_valid(a_h_valid), .h_finish(h_finish), .h_in(a_h_in), .h_data(h_data),
    .v_reset(a_v_reset), .v_valid(a_v_valid), .v_finish(v_finish), .v_in(a_v_in), .v_data(v_data),
    .rand_reset(a_rand_reset), .error(a_error));

  rbm_gibbs_scheduler #(.bitlength(BL), .visible_dim(VD), .hidden_dim(HD),
                        .gibbs_steps(0), .timeout_cycles(TMO)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .vis_in(vis_in),
    .busy(b_busy), .done(b_done), .vis_out(b_vis_out), .hid_out(b_hid_out),
    .h_reset(b_h_reset), .h_valid(b_h_valid), .h_finish(h_finish), .h_in(b_h_in), .h_data(h_data),
    .v_reset(b_v_reset), .v_valid(b_v_valid), .v_finish(v_finish), .v_in(b_v_in), .v_data(v_data),
    .rand_reset(b_rand_reset), .error(b_error));

  // Selected instance view (sel=0 -> A, sel=1 -> B)
  logic sel = 1'b0;
  wire m_busy = sel ? b_busy : a_busy;
  wire m_done = sel ? b_done : a_done;
  wire m_h_reset = sel ? b_h_reset : a_h_reset;
  wire m_h_valid = sel ? b_h_valid : a_h_valid;
  wire m_v_reset = sel ? b_v_reset : a_v_reset;
  wire m_v_valid = sel ? b_v_valid : a_v_valid;
  wire m_rand_reset = sel ? b_rand_reset : a_rand_reset;
  wire m_error = sel ? b_error : a_error;
  wire [VW-1:0] m_vis_out = sel ? b_vis_out : a_vis_out;
  wire [VW-1:0] m_h_in = sel ? b_h_in : a_h_in;
  wire [HW-1:0] m_hid_out = sel ? b_hid_out : a_hid_out;
  wire [HW-1:0] m_v_in = sel ? b_v_in : a_v_in;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vw();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r[VW-1:0];
  endfunction

  function automatic logic [HW-1:0] rand_hw();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[HW-1:0];
  endfunction

  // Stub layers and monitor state
  int lat_h = 1, lat_v = 1, h_cnt = 0, v_cnt = 0;
  bit fixed = 1'b0, mon_en = 1'b0, b_v_seen = 1'b0;
  logic [HW-1:0] h_pat, vinq[$], hq[$];
  logic [VW-1:0] v_pat, vq[$], hinq[$];
  string log_s = "";
  int done_cnt = 0, rr_cnt = 0;
  bit prev_h_reset = 1'b0, prev_v_reset = 1'b0, prev_h_valid = 1'b0, prev_v_valid = 1'b0;

  // Layer stubs raise finish in the lat-th valid cycle; outside valid they
  // emit stray finishes and garbage data that the scheduler must ignore.
  always @(negedge clock) begin
    if (m_h_valid) begin
      if (h_cnt == 0) begin
        h_data = fixed ? h_pat : rand_hw();
        hq.push_back(h_data);
        hinq.push_back(m_h_in);
      end
      h_cnt++;
      h_finish = (h_cnt == lat_h);
    end else begin
      h_cnt = 0;
      h_finish = 1'($urandom_range(0, 1));
      h_data = rand_hw();
    end
    if (m_v_valid) begin
      if (v_cnt == 0) begin
        v_data = fixed ? v_pat : rand_vw();
        vq.push_back(v_data);
        vinq.push_back(m_v_in);
      end
      v_cnt++;
      v_finish = (v_cnt == lat_v);
    end else begin
      v_cnt = 0;
      v_finish = 1'($urandom_range(0, 1));
      v_data = rand_vw();
    end
    if (mon_en) begin
      if (m_h_reset) log_s = {log_s, "H"};
      if (m_v_reset) log_s = {log_s, "V"};
      if (m_done) begin
        log_s = {log_s, "D"};
        done_cnt++;
      end
      if (m_rand_reset) rr_cnt++;
      if (b_v_reset || b_v_valid) b_v_seen = 1'b1;
      if (m_h_valid && !prev_h_valid) chk("h_valid_follows_h_reset", 192'(prev_h_reset), 192'd1);
      if (m_v_valid && !prev_v_valid) chk("v_valid_follows_v_reset", 192'(prev_v_reset), 192'd1);
      if (m_h_valid) chk("h_in_stable", 192'(m_h_in), 192'(hinq[$]));
      if (m_v_valid) chk("v_in_stable", 192'(m_v_in), 192'(vinq[$]));
      if (m_h_valid || m_v_valid || m_h_reset || m_v_reset || m_done)
        chk("busy_during_run", 192'(m_busy), 192'd1);
    end
    prev_h_reset = m_h_reset;
    prev_v_reset = m_v_reset;
    prev_h_valid = m_h_valid;
    prev_v_valid = m_v_valid;
  end

  bit seeded_model[2];

  // One run on the selected instance; mode 0 = start pulse, 1 = start held
  // through the run and DONE, 2 = random start noise while busy.
  task automatic run_one(input bit s, input int mode, input int lh, input int lv,
                         input logic [VW-1:0] vin, input int exp_cyc, input string tag);
    int g, cyc, exp_rr;
    string exp_log;
    g = s ? 0 : 1;
    exp_rr = seeded_model[s] ? 0 : 1;
    seeded_model[s] = 1'b1;
    sel = s; lat_h = lh; lat_v = lv; vis_in = vin;
    hq.delete(); vq.delete(); hinq.delete(); vinq.delete();
    log_s = ""; done_cnt = 0; rr_cnt = 0;
    @(negedge clock);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock); #1;
    if (mode != 1) begin start_a = 1'b0; start_b = 1'b0; end
    cyc = 0;
    @(negedge clock);
    while (!m_done && cyc < 400) begin
      if (mode == 2) begin
        if (s) start_b = 1'($urandom_range(0, 1)); else start_a = 1'($urandom_range(0, 1));
      end
      cyc++;
      @(negedge clock);
    end
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clock); #1;
    chk({tag, " cycles_to_done"}, 192'(cyc), 192'(exp_cyc));
    exp_log = "H";
    for (int k = 0; k < g; k++) exp_log = {exp_log, "VH"};
    exp_log = {exp_log, "D"};
    chk_str({tag, " phase_order"}, log_s, exp_log);
    chk({tag, " done_count"}, 192'(done_cnt), 192'd1);
    chk({tag, " rand_reset_count"}, 192'(rr_cnt), 192'(exp_rr));
    chk({tag, " idle_after"}, 192'({m_busy, m_done, m_error}), 192'd0);
    chk({tag, " other_idle"}, 192'(s ? a_busy : b_busy), 192'd0);
    chk({tag, " h_phases"}, 192'(hq.size()), 192'(g + 1));
    chk({tag, " v_phases"}, 192'(vq.size()), 192'(g));
    if (hq.size() == g + 1 && vq.size() == g) begin
      chk({tag, " vis_out"}, 192'(m_vis_out), 192'((g == 0) ? vin : vq[g-1]));
      chk({tag, " hid_out"}, 192'(m_hid_out), 192'(hq[g]));
      chk({tag, " h_in_first"}, 192'(hinq[0]), 192'(vin));
      for (int k = 1; k <= g; k++) chk({tag, " h_in_routed"}, 192'(hinq[k]), 192'(vq[k-1]));
      for (int k = 0; k < g; k++) chk({tag, " v_in_routed"}, 192'(vinq[k]), 192'(hq[k]));
    end
    if (s) chk({tag, " no_v_phase_gibbs0"}, 192'(b_v_seen), 192'd0);
  endtask

  typedef struct {
    bit            inst;
    int            mode;
    int            lh;
    int            lv;
    bit            fix;
    logic [VW-1:0] vin;
    int            exp_cyc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, lh, lv, cnt, bound;
    bit s;
    logic [14:0] vbits;
    vbits = 15'h2AAA;
    for (int i = 0; i < HD; i++) h_pat[i*BL +: BL] = (i % 2 == 0) ? 12'd1 : 12'd0;
    for (int i = 0; i < VD; i++) v_pat[i*BL +: BL] = {11'd0, vbits[i]};
    tbl[0] = '{1'b0, 0, 6, 6, 1'b1, {VW{1'b1}}, 21};
    tbl[1] = '{1'b0, 1, 2, 5, 1'b0, rand_vw(), 12};
    tbl[2] = '{1'b1, 0, 6, 1, 1'b0, rand_vw(), 7};
    tbl[3] = '{1'b1, 2, 1, 1, 1'b0, rand_vw(), 2};
    tbl[4] = '{1'b0, 2, 1, 1, 1'b0, rand_vw(), 6};
    tbl[5] = '{1'b0, 0, 3, 7, 1'b0, rand_vw(), 16};

    repeat (3) @(negedge clock);
    #1;
    chk("reset_state_a", 192'({a_busy, a_done, a_h_valid, a_v_valid, a_h_reset, a_v_reset, a_rand_reset, a_error}), 192'(8'b0000_1110));
    chk("reset_state_b", 192'({b_busy, b_done, b_h_valid, b_v_valid, b_h_reset, b_v_reset, b_rand_reset, b_error}), 192'(8'b0000_1110));
    chk("reset_outputs_a", 192'({a_vis_out, a_hid_out} != '0), 192'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("release_strobes_a", 192'({a_h_reset, a_v_reset, a_rand_reset, a_busy}), 192'd0);
    chk("release_strobes_b", 192'({b_h_reset, b_v_reset, b_rand_reset, b_busy}), 192'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      fixed = tbl[i].fix;
      run_one(tbl[i].inst, tbl[i].mode, tbl[i].lh, tbl[i].lv, tbl[i].vin, tbl[i].exp_cyc, $sformatf("vec%0d", i));
    end
    fixed = 1'b0;

    // Randomised runs against the latency model (G+1) hidden + G visible phases
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      g = s ? 0 : 1;
      lh = $urandom_range(1, 7);
      lv = $urandom_range(1, 7);
      run_one(s, $urandom_range(0, 2), lh, lv, rand_vw(), (g + 1) * (1 + lh) + g * (1 + lv), $sformatf("rnd%0d", i));
    end

    // Reset in the third V_RUN cycle aborts at once; next run reseeds
    sel = 1'b0; lat_h = 4; lat_v = 7; vis_in = rand_vw();
    @(negedge clock); start_a = 1'b1;
    @(posedge clock); #1; start_a = 1'b0;
    cnt = 0; bound = 0;
    while (cnt < 3 && bound < 100) begin
      @(negedge clock);
      if (a_v_valid) cnt++;
      bound++;
    end
    chk("abort_reached_v_run3", 192'(cnt), 192'd3);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_state_a", 192'({a_busy, a_done, a_h_valid, a_v_valid, a_h_reset, a_v_reset, a_rand_reset, a_error}), 192'(8'b0000_1110));
    chk("abort_outputs_a", 192'({a_vis_out, a_hid_out} != '0), 192'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_release_a", 192'({a_h_reset, a_v_reset, a_rand_reset, a_busy, a_done}), 192'd0);
    seeded_model[0] = 1'b0; seeded_model[1] = 1'b0;
    mon_en = 1'b1;
    run_one(1'b0, 0, 3, 2, rand_vw(), 2 * 4 + 3, "after_abort");

`ifdef RBM_SCHED_TIMEOUT_EN
    // Watchdog: hidden layer never finishes
    sel = 1'b0; lat_h = 1000; done_cnt = 0;
    @(negedge clock); start_a = 1'b1;
    @(posedge clock); #1; start_a = 1'b0;
    cnt = 0; bound = 0;
    @(negedge clock);
    while (!a_h_valid && bound < 20) begin @(negedge clock); bound++; end
    while (a_h_valid && cnt < 50) begin cnt++; @(negedge clock); end
    #1;
    chk("timeout_run_cycles", 192'(cnt), 192'(TMO));
    chk("timeout_flags", 192'({a_error, a_busy, a_h_valid}), 192'(3'b100));
    repeat (4) @(negedge clock);
    #1;
    chk("timeout_error_sticky", 192'(a_error), 192'd1);
    chk("timeout_no_done", 192'(done_cnt), 192'd0);
    run_one(1'b0, 0, 2, 3, rand_vw(), 2 * 3 + 4, "after_timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
